cache_requester: RTL and testbench

Initiator-side driver for the single-cycle combinational cache port. It accepts load/store commands over a valid/ready handshake and drives address, enables and write data to the cache. It samples the cache's hit/miss/abort flags, retries on miss and pulses recover after an abort. It sits between the core's memory stage, or a bench sequencer, and the cache, and returns one response per command.

---
 rtl/cache_req_pkg.sv | 18 +
 rtl/cache_req_sat_cnt.sv | 26 ++
 rtl/cache_requester.sv | 170 +++++++++++++++++
 tb/tb_cache_requester.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_req_pkg.sv
// cache_req_pkg
// Shared definitions for the cache requester: the controller state encoding
// and the response error codes returned on o_rsp_err.
package cache_req_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RECOVER = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_ABORT    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_MISALIGN = 2'b11;

endpackage

// File: rtl/cache_req_sat_cnt.sv
// cache_req_sat_cnt
// Saturating up-counter. It counts once per cycle while inc is high and
// sticks at all-ones. Only reset clears it.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-high reset, clears count
//   inc      count this cycle
//   count    current value, WIDTH bits
module cache_req_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_requester.sv
// cache_requester
// Initiator-side driver for a single-cycle combinational cache port. It
// takes one load/store command at a time, drives the cache address, enables
// and write data, and retries on miss. After an abort it pulses recover for
// one cycle. It returns exactly one response per accepted command.
// Ports:
//   i_clk, i_reset               clock and asynchronous active-high reset
//   i_cmd_* / o_cmd_ready        command handshake (write, addr, wdata)
//   o_rsp_* / i_rsp_ready        response handshake (data, err)
//   o_address, o_data            cache address and write data
//   o_rd_en, o_wr_en, o_recover  cache controls
//   i_data, i_hit, i_miss, i_abort  cache read data and status
//   o_miss_count                 saturating count of miss cycles since reset
module cache_requester
  import cache_req_pkg::*;
#(
  parameter int MAX_RETRY = 15,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_write,
  input  logic [31:0]      i_cmd_addr,
  input  logic [31:0]      i_cmd_wdata,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_data,
  output logic [1:0]       o_rsp_err,
  output logic [31:0]      o_address,
  output logic [31:0]      o_data,
  input  logic [31:0]      i_data,
  input  logic             i_hit,
  input  logic             i_miss,
  input  logic             i_abort,
  output logic             o_rd_en,
  output logic             o_wr_en,
  output logic             o_recover,
  output logic [CNT_W-1:0] o_miss_count
);

  localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

  state_t      state_reg;
  logic [7:0]  retry_reg;
  logic        write_reg;
  logic        cmd_ready_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_data_reg;
  logic [1:0]  rsp_err_reg;
  logic [31:0] address_reg;
  logic [31:0] data_reg;
  logic        rd_en_reg;
  logic        wr_en_reg;
  logic        recover_reg;
  logic        miss_cycle;
  logic        unused_miss;

  // A REQ cycle without a flag is handled exactly like a flagged miss. As a
  // result, i_miss does not change behaviour: anything that is neither abort
  // nor hit counts as a miss.
  assign miss_cycle  = (state_reg == REQ) && !i_abort && !i_hit;
  assign unused_miss = i_miss;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg     <= IDLE;
      retry_reg     <= '0;
      write_reg     <= 1'b0;
      cmd_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= ERR_OK;
      address_reg   <= '0;
      data_reg      <= '0;
      rd_en_reg     <= 1'b0;
      wr_en_reg     <= 1'b0;
      recover_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_cmd_valid) begin
            write_reg     <= i_cmd_write;
            cmd_ready_reg <= 1'b0;
            if (i_cmd_addr[1:0] != 2'b00) begin
              // Misaligned: answer at once and never touch the cache.
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_data_reg  <= '0;
              rsp_err_reg   <= ERR_MISALIGN;
            end else begin
              state_reg   <= REQ;
              retry_reg   <= '0;
              address_reg <= i_cmd_addr;
              data_reg    <= i_cmd_wdata;
              rd_en_reg   <= !i_cmd_write;
              wr_en_reg   <= i_cmd_write;
            end
          end
        end
        REQ: begin
          if (i_abort) begin
            // Abort beats hit, so a store that hits in the same cycle is
            // treated as not committed.
            state_reg   <= RECOVER;
            rd_en_reg   <= 1'b0;
            wr_en_reg   <= 1'b0;
            recover_reg <= 1'b1;
          end else if (i_hit) begin
            // Drop enables at the committing edge so a store is written once.
            state_reg     <= RESP;
            rd_en_reg     <= 1'b0;
            wr_en_reg     <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= write_reg ? 32'd0 : i_data;
            rsp_err_reg   <= ERR_OK;
          end else begin
            retry_reg <= retry_reg + 8'd1;
            if ((retry_reg + 8'd1) == RETRY_LIMIT) begin
              state_reg     <= RESP;
              rd_en_reg     <= 1'b0;
              wr_en_reg     <= 1'b0;
              rsp_valid_reg <= 1'b1;
              rsp_data_reg  <= '0;
              rsp_err_reg   <= ERR_TIMEOUT;
            end
          end
        end
        RECOVER: begin
          state_reg     <= RESP;
          recover_reg   <= 1'b0;
          rsp_valid_reg <= 1'b1;
          rsp_data_reg  <= '0;
          rsp_err_reg   <= ERR_ABORT;
        end
        RESP: begin
          if (i_rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  cache_req_sat_cnt #(
    .WIDTH(CNT_W)
  ) u_miss_cnt (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .inc    (miss_cycle),
    .count  (o_miss_count)
  );

  assign o_cmd_ready = cmd_ready_reg;
  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_data  = rsp_data_reg;
  assign o_rsp_err   = rsp_err_reg;
  assign o_address   = address_reg;
  assign o_data      = data_reg;
  assign o_rd_en     = rd_en_reg;
  assign o_wr_en     = wr_en_reg;
  assign o_recover   = recover_reg;

endmodule

// File: tb/tb_cache_requester.sv
`timescale 1ns/1ps
module tb_cache_requester;

  localparam int CNT_W = 16;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
  } rsp_t;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_cmd_valid = 1'b0;
  logic             o_cmd_ready;
  logic             i_cmd_write = 1'b0;
  logic [31:0]      i_cmd_addr = '0;
  logic [31:0]      i_cmd_wdata = '0;
  logic             o_rsp_valid;
  logic             i_rsp_ready = 1'b0;
  logic [31:0]      o_rsp_data;
  logic [1:0]       o_rsp_err;
  logic [31:0]      o_address;
  logic [31:0]      o_data;
  logic [31:0]      i_data;
  logic             i_hit;
  logic             i_miss;
  logic             i_abort;
  logic             o_rd_en;
  logic             o_wr_en;
  logic             o_recover;
  logic [CNT_W-1:0] o_miss_count;

  int checks = 0;
  int errors = 0;
  rsp_t exp_q[$];

  cache_requester #(
    .MAX_RETRY(4),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_write (i_cmd_write),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_wdata (i_cmd_wdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err),
    .o_address   (o_address),
    .o_data      (o_data),
    .i_data      (i_data),
    .i_hit       (i_hit),
    .i_miss      (i_miss),
    .i_abort     (i_abort),
    .o_rd_en     (o_rd_en),
    .o_wr_en     (o_wr_en),
    .o_recover   (o_recover),
    .o_miss_count(o_miss_count)
  );

  always #5 i_clk = ~i_clk;

  // Cache model: combinational status. The first cfg_miss enabled cycles of
  // each access miss; cfg_abort raises abort together with hit.
  logic [31:0] cache_mem [0:63];
  int  cfg_miss = 0;
  bit  cfg_abort = 1'b0;
  int  en_run = 0;
  int  en_cycles = 0;
  int  rec_cycles = 0;

  always_comb begin
    i_hit   = 1'b0;
    i_miss  = 1'b0;
    i_abort = 1'b0;
    if (o_rd_en || o_wr_en) begin
      if (cfg_abort) begin
        i_abort = 1'b1;
        i_hit   = 1'b1;
      end else if (en_run < cfg_miss) begin
        i_miss = 1'b1;
      end else begin
        i_hit = 1'b1;
      end
    end
  end

  assign i_data = cache_mem[o_address[7:2]];

  always @(posedge i_clk) begin
    if (o_rd_en || o_wr_en) en_cycles <= en_cycles + 1;
    if (o_recover) rec_cycles <= rec_cycles + 1;
    if (i_reset) begin
      for (int k = 0; k < 64; k++) cache_mem[k] <= 32'd0;
      cache_mem[4] <= 32'hDEADBEEF;
      en_run <= 0;
    end else begin
      if (o_wr_en && i_hit && !i_abort) cache_mem[o_address[7:2]] <= o_data;
      en_run <= (o_rd_en || o_wr_en) ? en_run + 1 : 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, o_cmd_ready, 1);
    chk({tag, "_rsp_valid"}, o_rsp_valid, 0);
    chk({tag, "_rd_en"}, o_rd_en, 0);
    chk({tag, "_wr_en"}, o_wr_en, 0);
    chk({tag, "_recover"}, o_recover, 0);
    chk({tag, "_address"}, o_address, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_rsp_data"}, o_rsp_data, 0);
    chk({tag, "_rsp_err"}, o_rsp_err, 0);
    chk({tag, "_miss_count"}, o_miss_count, 0);
  endtask

  // Issue one command, expect the response after exp_lat cycles, hold off
  // i_rsp_ready for hold cycles, then compare against the scoreboard.
  task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data,
                         input logic [1:0] exp_err, input int hold,
                         input int exp_lat, input int exp_en);
    int   en0;
    int   lat;
    rsp_t e;
    rsp_t got;
    e.data = exp_data;
    e.err  = exp_err;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    en0 = en_cycles;
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = addr;
    i_cmd_wdata = wdata;
    @(negedge i_clk);
    chk({tag, "_cmd_ready"}, o_cmd_ready, 1);
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge i_clk);
      if (c == 1 && exp_en > 0) begin
        chk({tag, "_address"}, o_address, addr);
        chk({tag, "_rd_en"}, o_rd_en, !wr);
        chk({tag, "_wr_en"}, o_wr_en, wr);
        if (wr) chk({tag, "_wdata"}, o_data, wdata);
      end
      if (o_rsp_valid) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    if (lat == 0) begin
      void'(exp_q.pop_front());
      return;
    end
    got.data = o_rsp_data;
    got.err  = o_rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      chk({tag, "_hold_valid"}, o_rsp_valid, 1);
      chk({tag, "_hold_cmd_ready"}, o_cmd_ready, 0);
      chk({tag, "_hold_data"}, o_rsp_data, got.data);
      chk({tag, "_hold_err"}, o_rsp_err, got.err);
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rsp_ready = 1'b0;
    e = exp_q.pop_front();
    chk({tag, "_rsp_data"}, got.data, e.data);
    chk({tag, "_rsp_err"}, got.err, e.err);
    @(negedge i_clk);
    chk({tag, "_post_valid"}, o_rsp_valid, 0);
    chk({tag, "_post_cmd_ready"}, o_cmd_ready, 1);
    chk({tag, "_en_cycles"}, en_cycles - en0, exp_en);
    $display("txn %s wr=%0d addr=%08h data=%08h err=%0d lat=%0d", tag, wr, addr,
             got.data, got.err, lat);
  endtask

  initial begin
    int rec0;

    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    check_reset_outputs("reset");

    run_cmd("load_hit", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 0, 2, 1);
    run_cmd("store", 1'b1, 32'h20, 32'h12345678, 32'h0, 2'b00, 0, 2, 1);
    run_cmd("load_back", 1'b0, 32'h20, 32'h0, 32'h12345678, 2'b00, 0, 2, 1);
    chk("hits_miss_count", o_miss_count, 0);

    cfg_miss = 3;
    run_cmd("miss_retry", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 0, 5, 4);
    chk("miss_retry_count", o_miss_count, 3);

    cfg_miss = 255;
    run_cmd("timeout", 1'b0, 32'h24, 32'h0, 32'h0, 2'b10, 0, 5, 4);
    chk("timeout_count", o_miss_count, 7);
    cfg_miss = 0;

    cfg_abort = 1'b1;
    rec0 = rec_cycles;
    run_cmd("abort", 1'b1, 32'h30, 32'hAAAA5555, 32'h0, 2'b01, 0, 3, 1);
    chk("abort_recover_cycles", rec_cycles - rec0, 1);
    cfg_abort = 1'b0;
    run_cmd("abort_not_committed", 1'b0, 32'h30, 32'h0, 32'h0, 2'b00, 0, 2, 1);
    chk("abort_count", o_miss_count, 7);

    run_cmd("misalign", 1'b0, 32'h13, 32'h0, 32'h0, 2'b11, 0, 1, 0);
    run_cmd("backpressure", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 5, 2, 1);

    // Reset while the requester is retrying: outputs clear at once, no response.
    cfg_miss = 255;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b0;
    i_cmd_addr  = 32'h10;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    @(posedge i_clk);
    #2;
    chk("rst_pre_rd_en", o_rd_en, 1);
    i_reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge i_clk);
    #1;
    i_reset  = 1'b0;
    cfg_miss = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk("rst_no_rsp", o_rsp_valid, 0);
      chk("rst_no_rd_en", o_rd_en, 0);
    end
    $display("txn reset_mid_req dropped");

    run_cmd("after_reset", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 0, 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
